// File: rtl/lemon_ctrl.sv
// lemon_ctrl: multi-cycle fetch/decode/execute sequencer for the LemonPC core datapath.
// Optional build macro LEMON_CTRL_PERF_EN adds cycle and retired-instruction counters.
module lemon_ctrl #(
   parameter logic [63:0] RESET_PC      = 64'h8000_0000,
   parameter int unsigned FETCH_TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imem_req,
   output logic [63:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic [63:0] o_pc,
   output logic [31:0] o_inst,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rd,
   output logic [63:0] o_imm,
   output logic [3:0]  o_alu_sel,
   output logic        o_rf_wen,
   output logic        o_halted,
   output logic [1:0]  o_halt_code
`ifdef LEMON_CTRL_PERF_EN
   ,
   output logic [63:0] o_cycle_cnt,
   output logic [63:0] o_instret_cnt
`endif
);

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_FETCH  = 3'd1,
      S_WAIT   = 3'd2,
      S_DECODE = 3'd3,
      S_EXEC   = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [6:0]  OP_IMM     = 7'b0010011;
   localparam logic [31:0] INST_EBRK  = 32'h0010_0073;
   localparam logic [1:0]  HC_RUN     = 2'd0;
   localparam logic [1:0]  HC_EBREAK  = 2'd1;
   localparam logic [1:0]  HC_ILLEGAL = 2'd2;
   localparam logic [1:0]  HC_TIMEOUT = 2'd3;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [63:0] r_pc;
   logic [31:0] r_inst;
   logic [3:0]  r_alu_sel;
   logic [1:0]  r_halt_code;
   logic [1:0]  w_halt_code_nxt;
   logic [31:0] r_tcnt;
   logic [31:0] w_tcnt_inc;
   logic        w_timeout;
   logic        w_legal;
   logic [2:0]  w_funct3;

   assign w_funct3   = r_inst[14:12];
   assign w_legal    = (r_inst[6:0] == OP_IMM) &&
                       ((w_funct3 == 3'b000) || (w_funct3 == 3'b100) ||
                        (w_funct3 == 3'b110) || (w_funct3 == 3'b111));
   // Count including the current FETCH/WAIT cycle; zero limit disables the timeout.
   assign w_tcnt_inc = r_tcnt + 32'd1;
   assign w_timeout  = (FETCH_TIMEOUT != 32'd0) && (w_tcnt_inc == FETCH_TIMEOUT);

   always_comb begin
      w_state_nxt     = r_state;
      w_halt_code_nxt = r_halt_code;
      case (r_state)
         S_RESET: w_state_nxt = S_FETCH;
         S_FETCH: begin
            if (w_timeout) begin
               w_state_nxt     = S_HALT;
               w_halt_code_nxt = HC_TIMEOUT;
            end else if (i_imem_gnt) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            // Returned data takes priority over a timeout expiring in the same cycle.
            if (i_imem_rvalid) begin
               w_state_nxt = S_DECODE;
            end else if (w_timeout) begin
               w_state_nxt     = S_HALT;
               w_halt_code_nxt = HC_TIMEOUT;
            end
         end
         S_DECODE: begin
            if (w_legal) begin
               w_state_nxt = S_EXEC;
            end else begin
               w_state_nxt     = S_HALT;
               w_halt_code_nxt = (r_inst == INST_EBRK) ? HC_EBREAK : HC_ILLEGAL;
            end
         end
         S_EXEC:  w_state_nxt = S_FETCH;
         S_HALT:  w_state_nxt = S_HALT;
         default: w_state_nxt = S_RESET;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_RESET;
         r_pc        <= RESET_PC;
         r_inst      <= 32'd0;
         r_alu_sel   <= 4'd0;
         r_halt_code <= HC_RUN;
         r_tcnt      <= 32'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_halt_code <= w_halt_code_nxt;
         if ((r_state == S_FETCH) || (r_state == S_WAIT)) begin
            r_tcnt <= w_tcnt_inc;
         end else begin
            r_tcnt <= 32'd0;
         end
         if ((r_state == S_WAIT) && i_imem_rvalid) begin
            r_inst <= i_imem_rdata;
         end
         if ((r_state == S_DECODE) && w_legal) begin
            r_alu_sel <= {1'b0, w_funct3};
         end
         if (r_state == S_EXEC) begin
            r_pc <= r_pc + 64'd4;
         end
      end
   end

`ifdef LEMON_CTRL_PERF_EN
   logic [63:0] r_cycle_cnt;
   logic [63:0] r_instret_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cycle_cnt   <= 64'd0;
         r_instret_cnt <= 64'd0;
      end else begin
         if ((r_state != S_RESET) && (r_state != S_HALT)) begin
            r_cycle_cnt <= r_cycle_cnt + 64'd1;
         end
         if (r_state == S_EXEC) begin
            r_instret_cnt <= r_instret_cnt + 64'd1;
         end
      end
   end

   assign o_cycle_cnt   = r_cycle_cnt;
   assign o_instret_cnt = r_instret_cnt;
`endif

   assign o_imem_req  = (r_state == S_FETCH);
   assign o_imem_addr = r_pc;
   assign o_pc        = r_pc;
   assign o_inst      = r_inst;
   assign o_rs1       = r_inst[19:15];
   assign o_rd        = r_inst[11:7];
   assign o_imm       = {{52{r_inst[31]}}, r_inst[31:20]};
   assign o_alu_sel   = r_alu_sel;
   assign o_rf_wen    = (r_state == S_EXEC) && (r_inst[11:7] != 5'd0);
   assign o_halted    = (r_state == S_HALT);
   assign o_halt_code = r_halt_code;

endmodule

// File: tb/tb_lemon_ctrl.sv
// Bench for lemon_ctrl: directed and randomized instruction fetches against an instruction-level model.
module tb_lemon_ctrl;

   localparam logic [63:0] RST_PC  = 64'h8000_0000;
   localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_imem_gnt = 1'b0;
   logic        i_imem_rvalid = 1'b0;
   logic [31:0] i_imem_rdata = 32'd0;

   logic        o_imem_req, o_rf_wen, o_halted;
   logic [63:0] o_imem_addr, o_pc, o_imm;
   logic [31:0] o_inst;
   logic [4:0]  o_rs1, o_rd;
   logic [3:0]  o_alu_sel;
   logic [1:0]  o_halt_code;

   logic        wr_imem_req, wr_rf_wen, wr_halted;
   logic [63:0] wr_imem_addr, wr_pc, wr_imm;
   logic [31:0] wr_inst;
   logic [4:0]  wr_rs1, wr_rd;
   logic [3:0]  wr_alu_sel;
   logic [1:0]  wr_halt_code;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] exp_pc;

   lemon_ctrl #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(16)) u_dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
      .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
      .o_pc(o_pc), .o_inst(o_inst), .o_rs1(o_rs1), .o_rd(o_rd), .o_imm(o_imm),
      .o_alu_sel(o_alu_sel), .o_rf_wen(o_rf_wen), .o_halted(o_halted), .o_halt_code(o_halt_code)
   );

   // Second instance starting just below 2^64 sees the same traffic to exercise PC wrap.
   lemon_ctrl #(.RESET_PC(WRAP_PC), .FETCH_TIMEOUT(16)) u_wrap (
      .i_clk(i_clk), .i_rst(i_rst),
      .o_imem_req(wr_imem_req), .o_imem_addr(wr_imem_addr),
      .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
      .o_pc(wr_pc), .o_inst(wr_inst), .o_rs1(wr_rs1), .o_rd(wr_rd), .o_imm(wr_imm),
      .o_alu_sel(wr_alu_sel), .o_rf_wen(wr_rf_wen), .o_halted(wr_halted), .o_halt_code(wr_halt_code)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // 0 = executes, 1 = ebreak halt, 2 = illegal halt
   function automatic int classify(input logic [31:0] w);
      if (w == 32'h0010_0073) return 1;
      if (w[6:0] == 7'b0010011 &&
          (w[14:12] == 3'd0 || w[14:12] == 3'd4 || w[14:12] == 3'd6 || w[14:12] == 3'd7))
         return 0;
      return 2;
   endfunction

   function automatic logic [31:0] rand_legal();
      logic [31:0] r;
      logic [2:0]  f;
      r = $urandom;
      case ($urandom_range(0, 3))
         0:       f = 3'd0;
         1:       f = 3'd4;
         2:       f = 3'd6;
         default: f = 3'd7;
      endcase
      r[6:0]   = 7'b0010011;
      r[14:12] = f;
      return r;
   endfunction

   task automatic do_reset();
      i_rst = 1'b1;
      i_imem_gnt = 1'b0;
      i_imem_rvalid = 1'b0;
      step();
      step();
      chk("rst_pc", o_pc, RST_PC);
      chk("rst_inst", o_inst, 0);
      chk("rst_alu", o_alu_sel, 0);
      chk("rst_req", o_imem_req, 0);
      chk("rst_wen", o_rf_wen, 0);
      chk("rst_halted", o_halted, 0);
      chk("rst_code", o_halt_code, 0);
      chk("wrap_rst", {wr_pc ^ wr_imem_addr, 32'd0, wr_inst}, {WRAP_PC ^ WRAP_PC, 64'd0});
      chk("wrap_rst_fields", {wr_rs1, wr_rd, wr_alu_sel, wr_imem_req, wr_rf_wen, wr_halted, wr_halt_code},
          0);
      chk("wrap_rst_imm", wr_imm, 0);
      chk("wrap_rst_addr", wr_imem_addr, WRAP_PC);
      i_rst = 1'b0;
      step();
      exp_pc = RST_PC;
      chk("fetch_after_rst", o_imem_req, 1);
   endtask

   // Fetch and execute one instruction; gd cycles before gnt, rvd cycles before rvalid.
   task automatic run_inst(input logic [31:0] w, input int gd, input int rvd);
      logic [63:0]        pc0;
      logic signed [63:0] e_imm;
      int                 cls;
      pc0   = exp_pc;
      e_imm = $signed(w[31:20]);
      cls   = classify(w);
      for (int k = 0; k < gd; k++) begin
         chk("req_hold", o_imem_req, 1);
         chk("addr_hold", o_imem_addr, pc0);
         i_imem_gnt = 1'b0;
         i_imem_rvalid = 1'($urandom_range(0, 1));
         i_imem_rdata = $urandom;
         step();
      end
      chk("req_gnt", o_imem_req, 1);
      chk("addr_gnt", o_imem_addr, pc0);
      i_imem_gnt = 1'b1;
      i_imem_rvalid = 1'b1;
      i_imem_rdata = ~w;
      step();
      i_imem_gnt = 1'b0;
      i_imem_rvalid = 1'b0;
      chk("req_wait", o_imem_req, 0);
      for (int k = 0; k < rvd; k++) step();
      i_imem_rvalid = 1'b1;
      i_imem_rdata = w;
      step();
      i_imem_rvalid = 1'b0;
      i_imem_rdata = $urandom;
      chk("dec_inst", o_inst, w);
      chk("dec_rs1", o_rs1, w[19:15]);
      chk("dec_rd", o_rd, w[11:7]);
      chk("dec_imm", o_imm, e_imm);
      chk("dec_wen", o_rf_wen, 0);
      step();
      if (cls == 0) begin
         chk("ex_alu", o_alu_sel, {1'b0, w[14:12]});
         chk("ex_wen", o_rf_wen, (w[11:7] != 5'd0) ? 1 : 0);
         chk("ex_pc", o_pc, pc0);
         chk("ex_req", o_imem_req, 0);
         step();
         exp_pc = pc0 + 64'd4;
         chk("post_pc", o_pc, exp_pc);
         chk("post_wen", o_rf_wen, 0);
         chk("post_halted", o_halted, 0);
      end else begin
         chk("halt_flag", o_halted, 1);
         chk("halt_code", o_halt_code, cls);
         chk("halt_pc", o_pc, pc0);
         i_imem_gnt = 1'b1;
         repeat (3) step();
         i_imem_gnt = 1'b0;
         chk("halt_stay", o_halted, 1);
         chk("halt_code_hold", o_halt_code, cls);
         chk("halt_noreq", o_imem_req, 0);
         chk("halt_pc_frozen", o_pc, pc0);
      end
   endtask

   initial begin
      exp_pc = RST_PC;
      do_reset();

      // addi x1,x0,5 with earliest handshake
      run_inst(32'h0050_0093, 0, 0);
      chk("wrap_pc", wr_pc, 64'd0);
      chk("pc_first", o_pc, 64'h8000_0004);

      run_inst(rand_legal(), 3, 0);
      run_inst(32'h0000_0013, 0, 1);
      // 16th FETCH/WAIT cycle carries the data: data must win over timeout
      run_inst(rand_legal(), 7, 7);
      for (int n = 0; n < 20; n++) begin
         int gd;
         gd = $urandom_range(0, 6);
         run_inst(rand_legal(), gd, $urandom_range(0, 6));
      end

      // Reset in the middle of WAIT, then a stale response
      i_imem_gnt = 1'b1;
      step();
      i_imem_gnt = 1'b0;
      step();
      i_rst = 1'b1;
      #1;
      chk("midrst_req", o_imem_req, 0);
      chk("midrst_pc", o_pc, RST_PC);
      i_imem_rvalid = 1'b1;
      i_imem_rdata = 32'h0010_0073;
      step();
      i_rst = 1'b0;
      step();
      chk("restart_req", o_imem_req, 1);
      chk("restart_addr", o_imem_addr, RST_PC);
      step();
      chk("stale_ignored", o_halted, 0);
      i_imem_rvalid = 1'b0;
      exp_pc = RST_PC;
      run_inst(rand_legal(), 0, 2);

      do_reset();
      run_inst(32'h0010_0073, 1, 2);
      do_reset();
      run_inst(32'h0000_0033, 0, 0);
      do_reset();
      run_inst(32'h0010_1093, 2, 1);

      // Timeout: granted but no data ever returns
      do_reset();
      i_imem_gnt = 1'b1;
      step();
      i_imem_gnt = 1'b0;
      for (int k = 2; k <= 15; k++) step();
      chk("to_not_yet", o_halted, 0);
      step();
      chk("to_halted", o_halted, 1);
      chk("to_code", o_halt_code, 3);
      chk("to_pc", o_pc, RST_PC);
      chk("to_noreq", o_imem_req, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
